// File: rtl/library_checker.sv
// Checks a small standard-cell library (nand, nor, inverter, mux, D flop with clear/preset)
// against a reference model over a settle window followed by a fixed-length check window.
module library_checker #(
   parameter int SETTLE = 4,
   parameter int NVEC   = 64
) (
   input  logic        iClk,
   input  logic        iRstN,
   input  logic        iStart,
   input  logic        iA,
   input  logic        iB,
   input  logic        iSel,
   input  logic        iEnb,
   input  logic        iD,
   input  logic        iClr,
   input  logic        iPre,
   input  logic        iNand,
   input  logic        iNor,
   input  logic        iNot,
   input  logic        iMux,
   input  logic        iQp,
   input  logic        iQn,
   output logic        oBusy,
   output logic        oDone,
   output logic        oPass,
   output logic [7:0]  oErrCnt,
   output logic [5:0]  oErrMask,
   output logic [15:0] oVecCnt
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [7:0]  SETTLE_INIT = 8'(SETTLE);
   localparam logic [15:0] NVEC_LAST   = 16'(NVEC);

   // Written with if/else so an unknown observed value falls into the mismatch branch.
   function automatic logic mis(input logic obs, input logic exp);
      if (obs == exp) mis = 1'b0;
      else            mis = 1'b1;
   endfunction

   state_t      state_q, state_d;
   logic [7:0]  settle_q, settle_d;
   logic [7:0]  err_q, err_d;
   logic [5:0]  mask_q, mask_d;
   logic [15:0] vec_q, vec_d;
   logic        mq_q, mq_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;

   logic        exp_nand_s, exp_nor_s, exp_not_s, exp_mux_s, exp_qp_s, exp_qn_s;
   logic [5:0]  fail_s;

   // Reference cell outputs and per-cell mismatch bits.
   always_comb begin
      exp_nand_s = ~(iA & iB);
      exp_nor_s  = ~(iA | iB);
      exp_not_s  = ~iA;
      if (iEnb) exp_mux_s = iSel ? iB : iA;
      else      exp_mux_s = 1'b0;
      if (!iClr)      exp_qp_s = 1'b0;
      else if (!iPre) exp_qp_s = 1'b1;
      else            exp_qp_s = mq_q;
      exp_qn_s  = ~exp_qp_s;
      fail_s[0] = mis(iNand, exp_nand_s);
      fail_s[1] = mis(iNor,  exp_nor_s);
      fail_s[2] = mis(iNot,  exp_not_s);
      fail_s[3] = mis(iMux,  exp_mux_s);
      fail_s[4] = mis(iQp,   exp_qp_s);
      fail_s[5] = mis(iQn,   exp_qn_s);
   end

   // Sequencing, result accumulation and the flop model.
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      err_d    = err_q;
      mask_d   = mask_q;
      vec_d    = vec_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (iStart) begin
               state_d  = ST_SETTLE;
               settle_d = SETTLE_INIT;
               err_d    = 8'd0;
               mask_d   = 6'd0;
               vec_d    = 16'd0;
            end else begin
               state_d  = state_q;
            end
         end
         ST_SETTLE: begin
            if (settle_q <= 8'd1) state_d  = ST_CHECK;
            else                  settle_d = settle_q - 8'd1;
         end
         ST_CHECK: begin
            vec_d  = vec_q + 16'd1;
            mask_d = mask_q | fail_s;
            if ((|fail_s) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
            else                               err_d = err_q;
            if (vec_d == NVEC_LAST) state_d = ST_DONE;
            else                    state_d = ST_CHECK;
         end
         default: state_d = ST_IDLE;
      endcase

      if (!iClr)      mq_d = 1'b0;
      else if (!iPre) mq_d = 1'b1;
      else            mq_d = iD;

      busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
      done_d = (state_d == ST_DONE);
      pass_d = done_d && (err_d == 8'd0);
   end

   // State and result registers.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state_q  <= ST_IDLE;
         settle_q <= 8'd0;
         err_q    <= 8'd0;
         mask_q   <= 6'd0;
         vec_q    <= 16'd0;
         mq_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         err_q    <= err_d;
         mask_q   <= mask_d;
         vec_q    <= vec_d;
         mq_q     <= mq_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
      end
   end

   assign oBusy    = busy_q;
   assign oDone    = done_q;
   assign oPass    = pass_q;
   assign oErrCnt  = err_q;
   assign oErrMask = mask_q;
   assign oVecCnt  = vec_q;

endmodule

// File: tb/tb_library_checker.sv
// Directed bench for library_checker: golden cell models with injectable faults,
// expected run results queued at start and compared when the run completes.
module tb_library_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, start, start2;
   logic a, b, sel, enb, d, clr, pre;
   logic f_mux0, f_qp1;
   logic fq, g_qp;
   logic nand_o, nor_o, not_o, mux_o, qp_o, qn_o, nand_bad;

   logic        busy, done, pass;
   logic [7:0]  err;
   logic [5:0]  mask;
   logic [15:0] vec;
   logic        busy2, done2, pass2;
   logic [7:0]  err2;
   logic [5:0]  mask2;
   logic [15:0] vec2;

   // Golden D flop with asynchronous active-low clear (dominant) and preset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   fq <= 1'b0;
      else if (!clr) fq <= 1'b0;
      else if (!pre) fq <= 1'b1;
      else           fq <= d;
   end

   assign g_qp     = !clr ? 1'b0 : (!pre ? 1'b1 : fq);
   assign nand_o   = ~(a & b);
   assign nand_bad = a & b;
   assign nor_o    = ~(a | b);
   assign not_o    = ~a;
   assign mux_o    = f_mux0 ? 1'b0 : (enb ? (sel ? b : a) : 1'b0);
   assign qp_o     = f_qp1 ? 1'b1 : g_qp;
   assign qn_o     = ~g_qp;

   library_checker #(.SETTLE(4), .NVEC(64)) dut (
      .iClk(clk), .iRstN(rst_n), .iStart(start),
      .iA(a), .iB(b), .iSel(sel), .iEnb(enb), .iD(d), .iClr(clr), .iPre(pre),
      .iNand(nand_o), .iNor(nor_o), .iNot(not_o), .iMux(mux_o), .iQp(qp_o), .iQn(qn_o),
      .oBusy(busy), .oDone(done), .oPass(pass), .oErrCnt(err), .oErrMask(mask), .oVecCnt(vec)
   );

   library_checker #(.SETTLE(2), .NVEC(300)) dut2 (
      .iClk(clk), .iRstN(rst_n), .iStart(start2),
      .iA(a), .iB(b), .iSel(sel), .iEnb(enb), .iD(d), .iClr(clr), .iPre(pre),
      .iNand(nand_bad), .iNor(nor_o), .iNot(not_o), .iMux(mux_o), .iQp(qp_o), .iQn(qn_o),
      .oBusy(busy2), .oDone(done2), .oPass(pass2), .oErrCnt(err2), .oErrMask(mask2), .oVecCnt(vec2)
   );

   typedef struct {
      logic [7:0]  err;
      logic [5:0]  mask;
      logic [15:0] vec;
      logic        pass;
      int          busy;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   mode   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle of random stimulus with the fault window of the current mode applied.
   task automatic drive(input int i);
      a      = 1'($urandom);
      b      = 1'($urandom);
      sel    = 1'($urandom);
      enb    = 1'($urandom);
      d      = 1'($urandom);
      clr    = 1'b1;
      pre    = 1'b1;
      f_mux0 = 1'b0;
      f_qp1  = 1'b0;
      case (mode)
         1: if (i >= 10 && i <= 12) begin
               enb = 1'b1; sel = 1'b0; a = 1'b1; f_mux0 = 1'b1;
            end
         2, 3: if (i == 20 || i == 21) begin
               clr = 1'b0; pre = 1'b0; f_qp1 = (mode == 3);
            end
         default: ;
      endcase
   endtask

   task automatic run(input bit use2, input logic [7:0] e_err, input logic [5:0] e_mask,
                      input logic [15:0] e_vec, input logic e_pass, input int e_busy, input int bound);
      exp_t e, g;
      int   busy_cnt;
      bit   got;
      e.err = e_err; e.mask = e_mask; e.vec = e_vec; e.pass = e_pass; e.busy = e_busy;
      sb.push_back(e);
      busy_cnt = 0;
      got = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         drive(i);
         if (use2) start2 = (i == 0);
         else      start  = (i == 0) || (mode == 4 && i == 30);
         @(posedge clk);
         #1;
         if (use2 ? done2 : done) begin
            got = 1'b1;
            break;
         end
         if (use2 ? busy2 : busy) busy_cnt++;
      end
      @(negedge clk);
      start = 1'b0; start2 = 1'b0; clr = 1'b1; pre = 1'b1; f_mux0 = 1'b0; f_qp1 = 1'b0;
      check("done_seen", 32'(got), 32'd1);
      g = sb.pop_front();
      check("busy_cycles", 32'(busy_cnt), 32'(g.busy));
      check("err_cnt",  32'(use2 ? err2  : err),  32'(g.err));
      check("err_mask", 32'(use2 ? mask2 : mask), 32'(g.mask));
      check("vec_cnt",  32'(use2 ? vec2  : vec),  32'(g.vec));
      check("pass",     32'(use2 ? pass2 : pass), 32'(g.pass));
      check("busy_in_done", 32'(use2 ? busy2 : busy), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_pass"}, 32'(pass), 32'd0);
      check({tag, "_err"},  32'(err),  32'd0);
      check({tag, "_mask"}, 32'(mask), 32'd0);
      check({tag, "_vec"},  32'(vec),  32'd0);
   endtask

   initial begin
      rst_n = 1'b1; start = 1'b0; start2 = 1'b0;
      a = 1'b0; b = 1'b0; sel = 1'b0; enb = 1'b0; d = 1'b0; clr = 1'b1; pre = 1'b1;
      f_mux0 = 1'b0; f_qp1 = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_all_zero("reset");
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_no_start", 32'(busy), 32'd0);

      mode = 0; run(1'b0, 8'd0, 6'b000000, 16'd64, 1'b1, 68, 200);
      mode = 1; run(1'b0, 8'd3, 6'b001000, 16'd64, 1'b0, 68, 200);
      mode = 0; run(1'b0, 8'd0, 6'b000000, 16'd64, 1'b1, 68, 200);
      mode = 2; run(1'b0, 8'd0, 6'b000000, 16'd64, 1'b1, 68, 200);
      mode = 3; run(1'b0, 8'd2, 6'b010000, 16'd64, 1'b0, 68, 200);
      mode = 4; run(1'b0, 8'd0, 6'b000000, 16'd64, 1'b1, 68, 200);
      mode = 0; run(1'b1, 8'd255, 6'b000001, 16'd300, 1'b0, 302, 400);

      // Abort a run mid-check with a reset pulse placed between clock edges.
      mode = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (20) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_all_zero("mid_reset");
      @(negedge clk) rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         drive(0);
      end
      check("post_reset_busy", 32'(busy), 32'd0);
      check("post_reset_vec",  32'(vec),  32'd0);
      check("post_reset_done", 32'(done), 32'd0);
      run(1'b0, 8'd0, 6'b000000, 16'd64, 1'b1, 68, 200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/library_checker.md
LIBRARY_CHECKER -- requirements
Module: library_checker

Interface
REQ-001 Parameter SETTLE, default 4: cycles ignored after start, legal range 1..255.
REQ-002 Parameter NVEC, default 64: cycles checked per run, legal range 1..65535.
REQ-003 iClk  in  1  sole clock; the same net that clocks the ffd cell; all state updates on its rising edge.
REQ-004 iRstN  in  1  reset, asynchronous, active-low.
REQ-005 iStart  in  1  one-cycle pulse that begins a run.
REQ-006 iA, iB, iSel, iEnb, iD  in  1 each  stimulus seen by the cells.
REQ-007 iClr, iPre  in  1 each  ffd clear and preset, both active-low.
REQ-008 iNand, iNor, iNot, iMux, iQp, iQn  in  1 each  cell outputs under check.
REQ-009 oBusy  out  1  high in SETTLE or CHECK.
REQ-010 oDone  out  1  high in DONE.
REQ-011 oPass  out  1  oDone and oErrCnt==0.
REQ-012 oErrCnt  out  8  count of mismatching cycles; saturates at 255.
REQ-013 oErrMask  out  6  sticky per-check fail bits: [0] nand, [1] nor, [2] not, [3] mux, [4] qp, [5] qn.
REQ-014 oVecCnt  out  16  cycles checked so far in the current run.

Function
REQ-015 FSM states shall be IDLE, SETTLE, CHECK and DONE.
REQ-016 IDLE -> SETTLE on iStart; DONE -> SETTLE on iStart; iStart in SETTLE/CHECK shall be ignored.
REQ-017 Entry to SETTLE shall clear oErrCnt, oErrMask and oVecCnt and load the settle counter with SETTLE.
REQ-018 SETTLE shall last exactly SETTLE cycles with no checking, then go to CHECK.
REQ-019 CHECK shall last exactly NVEC cycles, then go to DONE; oVecCnt shall equal NVEC in DONE.
REQ-020 DONE shall hold all results unchanged until iStart or reset.
REQ-021 Expected nand = ~(iA&iB); nor = ~(iA|iB); not = ~iA.
REQ-022 Expected mux = iEnb ? (iSel ? iB : iA) : 0.
REQ-023 Internal flop model mQ shall update every rising edge in all states: !iClr -> 0; else !iPre -> 1; else iD (clear dominates preset).
REQ-024 Expected Qp = !iClr ? 0 : !iPre ? 1 : mQ (the value before the current edge); expected Qn = ~expected Qp.
REQ-025 Each CHECK cycle shall sample all six cell outputs at the rising edge and compare them to expected values computed from inputs sampled at the same edge.
REQ-026 Any mismatch in a cycle shall OR the failing bits into oErrMask and add exactly 1 to oErrCnt, regardless of how many bits failed.
REQ-027 oErrCnt at 255 shall stay 255 on further mismatches.
REQ-028 oVecCnt shall increment once per CHECK cycle.
REQ-029 The last CHECK cycle's comparison shall be counted before DONE asserts.
REQ-030 X/Z on a cell output during CHECK shall count as a mismatch.

Reset
REQ-031 iRstN low shall, without waiting for a clock edge, force IDLE, mQ=0, oBusy=0, oDone=0, oPass=0, oErrCnt=0, oErrMask=0 and oVecCnt=0.
REQ-032 Reset asserted mid-run shall abort the run; after release the block shall stay in IDLE until iStart.
REQ-033 Reset release shall be synchronous to iClk; the first active edge after release shall be a normal edge.

Verification
REQ-034 Correct cells, SETTLE=4, NVEC=64, random stimulus with iClr=iPre=1 -> oBusy for 68 cycles, then oDone=1, oPass=1, oErrCnt=0, oVecCnt=64.
REQ-035 Mux output forced to 0 for 3 CHECK cycles where expected is 1 -> oErrCnt=3, oErrMask=6'b001000, oPass=0.
REQ-036 iClr=0 and iPre=0 held together for 2 CHECK cycles with correct flop -> no errors; iQp forced 1 in that window -> oErrMask[4]=1.
REQ-037 NVEC=300, nand output inverted for all cycles -> oErrCnt=255 (saturated), oVecCnt=300.
REQ-038 iStart pulsed again during CHECK -> ignored, run length unchanged; iStart in DONE -> results cleared, new run starts.
REQ-039 iRstN pulsed low mid-CHECK between clock edges -> all outputs 0 immediately, IDLE after release, no activity until iStart.
